// File: rtl/apb_slave_regs.sv
// rtl/apb_slave_regs.sv - APB register slave with programmable wait states
//
// Ports:
//   hclk, hreset_n      clock, synchronous active-low reset
//   psel, penable,      APB request: select, access phase, direction,
//   pwrite, paddr,      byte address, write data
//   pwdata
//   prdata, pready,     APB response, all registered
//   pslverr
//   status_in           source for the read-only STATUS register (0x04)
//   ctrl_out            live CTRL register contents (0x00)

`ifndef PADDR_WIDTH
`define PADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

module apb_slave_regs #(
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                       hclk,
    input  logic                       hreset_n,
    input  logic                       psel,
    input  logic                       penable,
    input  logic                       pwrite,
    input  logic [`PADDR_WIDTH-1:0]    paddr,
    input  logic [`APB_DATA_WIDTH-1:0] pwdata,
    output logic [`APB_DATA_WIDTH-1:0] prdata,
    output logic                       pready,
    output logic                       pslverr,
    input  logic [`APB_DATA_WIDTH-1:0] status_in,
    output logic [`APB_DATA_WIDTH-1:0] ctrl_out
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                      state;
    logic [3:0]                  cnt;
    logic [2:0]                  addr_q;
    logic                        write_q;
    logic                        err_q;
    logic [`APB_DATA_WIDTH-1:0]  ctrl_q;
    // Indexed by word offset paddr[4:2]; slots 2..7 map to SCRATCH0..5.
    logic [`APB_DATA_WIDTH-1:0]  scratch [2:7];

    logic setup;
    logic setup_err;

    assign setup = psel && !penable;

    // Misaligned, beyond the 32-byte window, or a write to read-only STATUS.
    assign setup_err = (paddr[1:0] != 2'b00)
                    || (paddr[`PADDR_WIDTH-1:5] != '0)
                    || (pwrite && (paddr[4:2] == 3'd1));

    assign ctrl_out = ctrl_q;

    function automatic logic [`APB_DATA_WIDTH-1:0] read_reg(input logic [2:0] idx);
        case (idx)
            3'd0:    read_reg = ctrl_q;
            3'd1:    read_reg = status_in;
            default: read_reg = scratch[idx];
        endcase
    endfunction

    always_ff @(posedge hclk) begin
        if (!hreset_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            addr_q  <= 3'd0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
            ctrl_q  <= '0;
            for (int i = 2; i <= 7; i++) begin
                scratch[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    prdata  <= '0;
                    // penable without a preceding setup cycle is ignored here.
                    if (setup) begin
                        addr_q  <= paddr[4:2];
                        write_q <= pwrite;
                        err_q   <= setup_err;
                        if (WAIT_CYCLES == 0) begin
                            // Address is still on the bus, so respond from it directly.
                            state   <= RESP;
                            pready  <= 1'b1;
                            pslverr <= setup_err;
                            prdata  <= (!pwrite && !setup_err) ? read_reg(paddr[4:2]) : '0;
                        end else begin
                            state <= WAIT;
                            cnt   <= WAIT_LOAD;
                        end
                    end
                end

                WAIT: begin
                    if (!psel) begin
                        state   <= IDLE;
                        cnt     <= 4'd0;
                        pready  <= 1'b0;
                        pslverr <= 1'b0;
                        prdata  <= '0;
                    end else begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            state   <= RESP;
                            pready  <= 1'b1;
                            pslverr <= err_q;
                            prdata  <= (!write_q && !err_q) ? read_reg(addr_q) : '0;
                        end
                    end
                end

                RESP: begin
                    state   <= IDLE;
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    prdata  <= '0;
                    // Commit only on a completed, legal write; a dropped psel aborts it.
                    if (psel && penable && write_q && !err_q) begin
                        case (addr_q)
                            3'd0:    ctrl_q <= pwdata;
                            3'd1:    ;
                            default: scratch[addr_q] <= pwdata;
                        endcase
                    end
                end

                default: begin
                    state   <= IDLE;
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    prdata  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_slave_regs.sv
// tb/tb_apb_slave_regs.sv - directed self-checking bench for apb_slave_regs

module tb_apb_slave_regs;

    logic        hclk = 1'b0;
    logic        hreset_n;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] status_in;
    logic [31:0] prdata_a  [3];
    logic [31:0] ctrl_a    [3];
    logic [2:0]  pready_a;
    logic [2:0]  pslverr_a;

    int checks = 0;
    int errors = 0;

    always #5 hclk = ~hclk;

    // Instance 0: no wait states, 1: two wait states, 2: three wait states.
    apb_slave_regs #(.WAIT_CYCLES(0)) dut0 (
        .hclk(hclk), .hreset_n(hreset_n), .psel(psel[0]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a[0]),
        .pready(pready_a[0]), .pslverr(pslverr_a[0]), .status_in(status_in),
        .ctrl_out(ctrl_a[0]));

    apb_slave_regs #(.WAIT_CYCLES(2)) dut2 (
        .hclk(hclk), .hreset_n(hreset_n), .psel(psel[1]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a[1]),
        .pready(pready_a[1]), .pslverr(pslverr_a[1]), .status_in(status_in),
        .ctrl_out(ctrl_a[1]));

    apb_slave_regs #(.WAIT_CYCLES(3)) dut3 (
        .hclk(hclk), .hreset_n(hreset_n), .psel(psel[2]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a[2]),
        .pready(pready_a[2]), .pslverr(pslverr_a[2]), .status_in(status_in),
        .ctrl_out(ctrl_a[2]));

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] status;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [31:0] exp_ctrl;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string name, input int d);
        chk({name, "_pready"},  {31'd0, pready_a[d]},  32'd0);
        chk({name, "_pslverr"}, {31'd0, pslverr_a[d]}, 32'd0);
        chk({name, "_prdata"},  prdata_a[d],           32'd0);
    endtask

    // Full transfer; returns response and the number of low-pready access cycles.
    task automatic xfer(input int d, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic er, output int waits);
        @(negedge hclk);
        psel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
        @(negedge hclk);
        penable = 1'b1;
        waits = 0;
        while (pready_a[d] !== 1'b1 && waits < 40) begin
            chk("wait_pslverr", {31'd0, pslverr_a[d]}, 32'd0);
            waits++;
            @(negedge hclk);
        end
        if (waits >= 40) chk("pready_timeout", 32'd1, 32'd0);
        rd = prdata_a[d];
        er = pslverr_a[d];
        @(negedge hclk);
        psel[d] = 1'b0; penable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          w;

        vecs[0]  = '{1'b1, 32'h00, 32'hA5A5_0001, 32'h0,         32'h0,         1'b0, 32'hA5A5_0001};
        vecs[1]  = '{1'b0, 32'h00, 32'h0,         32'h0,         32'hA5A5_0001, 1'b0, 32'hA5A5_0001};
        vecs[2]  = '{1'b1, 32'h08, 32'h0000_1234, 32'h0,         32'h0,         1'b0, 32'hA5A5_0001};
        vecs[3]  = '{1'b1, 32'h1C, 32'hCAFE_F00D, 32'h0,         32'h0,         1'b0, 32'hA5A5_0001};
        vecs[4]  = '{1'b0, 32'h1C, 32'h0,         32'h0,         32'hCAFE_F00D, 1'b0, 32'hA5A5_0001};
        vecs[5]  = '{1'b1, 32'h04, 32'h0000_FFFF, 32'h1111_2222, 32'h0,         1'b1, 32'hA5A5_0001};
        vecs[6]  = '{1'b0, 32'h04, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 32'hA5A5_0001};
        vecs[7]  = '{1'b0, 32'h20, 32'h0,         32'hDEAD_BEEF, 32'h0,         1'b1, 32'hA5A5_0001};
        vecs[8]  = '{1'b1, 32'h02, 32'h5A5A_5A5A, 32'h0,         32'h0,         1'b1, 32'hA5A5_0001};
        vecs[9]  = '{1'b0, 32'h00, 32'h0,         32'h0,         32'hA5A5_0001, 1'b0, 32'hA5A5_0001};
        vecs[10] = '{1'b1, 32'h30, 32'h1234_5678, 32'h0,         32'h0,         1'b1, 32'hA5A5_0001};
        vecs[11] = '{1'b0, 32'h10, 32'h0,         32'h0,         32'h0,         1'b0, 32'hA5A5_0001};
        vecs[12] = '{1'b0, 32'h08, 32'h0,         32'h0,         32'h0000_1234, 1'b0, 32'hA5A5_0001};

        hreset_n = 1'b0; psel = 3'b000; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; status_in = '0;
        repeat (3) @(negedge hclk);
        for (int d = 0; d < 3; d++) begin
            chk_idle("reset", d);
            chk("reset_ctrl", ctrl_a[d], 32'h0);
        end
        hreset_n = 1'b1;

        // Table-driven transfers on the zero-wait instance.
        for (int i = 0; i < 13; i++) begin
            status_in = vecs[i].status;
            xfer(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, w);
            chk($sformatf("v%0d_waits", i), w, 32'd0);
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("v%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
            chk($sformatf("v%0d_ctrl", i), ctrl_a[0], vecs[i].exp_ctrl);
            chk_idle($sformatf("v%0d_after", i), 0);
        end

        // Back-to-back: write SCRATCH3 then read it with no idle cycle between.
        @(negedge hclk);
        psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h14; pwdata = 32'h11;
        @(negedge hclk);
        penable = 1'b1;
        chk("b2b_wr_pready", {31'd0, pready_a[0]}, 32'd1);
        @(negedge hclk);
        penable = 1'b0; pwrite = 1'b0;
        chk("b2b_gap_pready", {31'd0, pready_a[0]}, 32'd0);
        @(negedge hclk);
        penable = 1'b1;
        chk("b2b_rd_pready", {31'd0, pready_a[0]}, 32'd1);
        chk("b2b_rd_prdata", prdata_a[0], 32'h11);
        @(negedge hclk);
        psel[0] = 1'b0; penable = 1'b0;

        // penable without a setup cycle produces no response.
        @(negedge hclk);
        psel[0] = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h00; pwdata = 32'h0BAD;
        for (int i = 0; i < 3; i++) begin
            @(negedge hclk);
            chk_idle("noset", 0);
        end
        chk("noset_ctrl", ctrl_a[0], 32'hA5A5_0001);
        psel[0] = 1'b0; penable = 1'b0;

        // Three wait states.
        xfer(2, 1'b1, 32'h08, 32'h1234, rd, er, w);
        chk("w3_wr_waits", w, 32'd3);
        chk("w3_wr_err", {31'd0, er}, 32'd0);
        xfer(2, 1'b0, 32'h08, 32'h0, rd, er, w);
        chk("w3_rd_waits", w, 32'd3);
        chk("w3_rd_prdata", rd, 32'h0000_1234);
        chk("w3_rd_err", {31'd0, er}, 32'd0);

        // Two wait states: establish SCRATCH1, then abort a write to it.
        xfer(1, 1'b1, 32'h0C, 32'h5555, rd, er, w);
        chk("w2_wr_waits", w, 32'd2);
        @(negedge hclk);
        psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'hAAAA;
        @(negedge hclk);
        penable = 1'b1;
        chk("abort_c1_pready", {31'd0, pready_a[1]}, 32'd0);
        @(negedge hclk);
        chk("abort_c2_pready", {31'd0, pready_a[1]}, 32'd0);
        psel[1] = 1'b0; penable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge hclk);
            chk_idle("abort_after", 1);
        end
        xfer(1, 1'b0, 32'h0C, 32'h0, rd, er, w);
        chk("abort_next_waits", w, 32'd2);
        chk("abort_scratch1", rd, 32'h5555);
        chk("abort_next_err", {31'd0, er}, 32'd0);

        // Reset for one cycle during WAIT of a write to CTRL.
        @(negedge hclk);
        psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h00; pwdata = 32'h77;
        @(negedge hclk);
        penable = 1'b1;
        @(negedge hclk);
        hreset_n = 1'b0;
        @(negedge hclk);
        hreset_n = 1'b1;
        chk_idle("rst_mid", 2);
        chk("rst_mid_ctrl", ctrl_a[2], 32'h0);
        chk("rst_dut0_ctrl", ctrl_a[0], 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge hclk);
            chk_idle("rst_hold", 2);
            chk("rst_hold_ctrl", ctrl_a[2], 32'h0);
        end
        psel[2] = 1'b0; penable = 1'b0;
        xfer(2, 1'b0, 32'h00, 32'h0, rd, er, w);
        chk("rst_next_waits", w, 32'd3);
        chk("rst_next_ctrl", rd, 32'h0);
        xfer(2, 1'b0, 32'h08, 32'h0, rd, er, w);
        chk("rst_scratch0", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
